operand_fetch: RTL and testbench

Instruction-decode and operand-fetch stage sitting directly upstream of the 32×32 register file. Decodes a 32-bit MIPS-style instruction and drives the register-file read addresses. It captures both operands, with writeback bypass and `$0` forced to zero, into a valid/ready pipeline register for the execute stage. A 32-entry pending-write scoreboard stalls issue on RAW/WAW hazards until the producing writeback arrives.

---
 rtl/operand_fetch.sv | 233 +++++++++++++++++++++++
 tb/tb_operand_fetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: decodes a MIPS-style instruction, reads both source operands
// from the register file (with writeback bypass and $0 forced to zero), and
// registers them for the execute stage behind a valid/ready handshake. A
// pending-write scoreboard holds issue back on RAW/WAW hazards.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,

  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,

  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,

  input  logic              flush,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_op,
  output logic [5:0]        out_funct,
  output logic [DATA_W-1:0] out_rs_val,
  output logic [DATA_W-1:0] out_rt_val,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_wen
);

  localparam int NREGS = 1 << ADDR_W;

  // Opcodes that the decoder treats specially
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // Decoded fields of the incoming instruction
  logic [5:0]        dec_op;
  logic [5:0]        dec_funct;
  logic [ADDR_W-1:0] dec_rs;
  logic [ADDR_W-1:0] dec_rt;
  logic [ADDR_W-1:0] dec_rd;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_has_dest;
  logic [ADDR_W-1:0] dec_dest;
  logic              dec_uses_rt;
  logic              dec_wen;

  // Resolved operands
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  // Scoreboard and hazard detection
  logic [NREGS-1:0]  pending_q;
  logic [NREGS-1:0]  pending_d;
  logic [NREGS-1:0]  wb_mask;
  logic [NREGS-1:0]  live_pending;
  logic              hazard;
  logic              accept;

  // Output pipeline register
  logic              out_valid_q,  out_valid_d;
  logic [5:0]        out_op_q,     out_op_d;
  logic [5:0]        out_funct_q,  out_funct_d;
  logic [DATA_W-1:0] out_rs_val_q, out_rs_val_d;
  logic [DATA_W-1:0] out_rt_val_q, out_rt_val_d;
  logic [DATA_W-1:0] out_imm_q,    out_imm_d;
  logic [ADDR_W-1:0] out_dest_q,   out_dest_d;
  logic              out_wen_q,    out_wen_d;

  // Source value: $0 reads zero, a same-cycle writeback wins over the RF
  function automatic logic [DATA_W-1:0] resolve_src(
    input logic [ADDR_W-1:0] src,
    input logic [DATA_W-1:0] rf_data,
    input logic              byp_en,
    input logic [ADDR_W-1:0] byp_addr,
    input logic [DATA_W-1:0] byp_data
  );
    logic [DATA_W-1:0] val;
    if (src == '0) begin
      val = '0;
    end else if (byp_en && (byp_addr == src)) begin
      val = byp_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  // Split the instruction word into fields and classify the opcode
  always_comb begin
    dec_op       = in_instr[31:26];
    dec_rs       = in_instr[25:21];
    dec_rt       = in_instr[20:16];
    dec_rd       = in_instr[15:11];
    dec_funct    = in_instr[5:0];
    dec_imm      = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
    dec_has_dest = 1'b0;
    dec_dest     = '0;
    dec_uses_rt  = 1'b0;
    case (dec_op)
      OP_RTYPE: begin
        dec_has_dest = 1'b1;
        dec_dest     = dec_rd;
        dec_uses_rt  = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
        dec_has_dest = 1'b1;
        dec_dest     = dec_rt;
      end
      OP_SW, OP_BEQ: begin
        dec_uses_rt  = 1'b1;
      end
      default: begin
        dec_has_dest = 1'b0;
      end
    endcase
    dec_wen = dec_has_dest && (dec_dest != '0);
  end

  assign rf_raddr1 = dec_rs;
  assign rf_raddr2 = dec_rt;

  // Both operands are captured regardless of whether the opcode uses rt
  always_comb begin
    rs_val = resolve_src(dec_rs, rf_rdata1, wb_en, wb_addr, wb_data);
    rt_val = resolve_src(dec_rt, rf_rdata2, wb_en, wb_addr, wb_data);
  end

  // A pending bit being written back this cycle no longer blocks issue
  always_comb begin
    wb_mask = '0;
    if (wb_en) begin
      wb_mask[wb_addr] = 1'b1;
    end
    live_pending    = pending_q & ~wb_mask;
    live_pending[0] = 1'b0;
    hazard = live_pending[dec_rs]
           | (dec_uses_rt & live_pending[dec_rt])
           | (dec_wen & live_pending[dec_dest]);
  end

  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Scoreboard update: flush and writeback clear first, a new issue sets last
  always_comb begin
    pending_d = pending_q;
    if (flush && out_valid_q && out_wen_q) begin
      pending_d[out_dest_q] = 1'b0;
    end
    if (wb_en) begin
      pending_d[wb_addr] = 1'b0;
    end
    if (accept && dec_wen) begin
      pending_d[dec_dest] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Output register next state: load on accept, drop on consume or flush
  always_comb begin
    out_valid_d  = out_valid_q;
    out_op_d     = out_op_q;
    out_funct_d  = out_funct_q;
    out_rs_val_d = out_rs_val_q;
    out_rt_val_d = out_rt_val_q;
    out_imm_d    = out_imm_q;
    out_dest_d   = out_dest_q;
    out_wen_d    = out_wen_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_op_d     = dec_op;
      out_funct_d  = dec_funct;
      out_rs_val_d = rs_val;
      out_rt_val_d = rt_val;
      out_imm_d    = dec_imm;
      out_dest_d   = dec_dest;
      out_wen_d    = dec_wen;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      out_op_q     <= '0;
      out_funct_q  <= '0;
      out_rs_val_q <= '0;
      out_rt_val_q <= '0;
      out_imm_q    <= '0;
      out_dest_q   <= '0;
      out_wen_q    <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_op_q     <= out_op_d;
      out_funct_q  <= out_funct_d;
      out_rs_val_q <= out_rs_val_d;
      out_rt_val_q <= out_rt_val_d;
      out_imm_q    <= out_imm_d;
      out_dest_q   <= out_dest_d;
      out_wen_q    <= out_wen_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_op     = out_op_q;
  assign out_funct  = out_funct_q;
  assign out_rs_val = out_rs_val_q;
  assign out_rt_val = out_rt_val_q;
  assign out_imm    = out_imm_q;
  assign out_dest   = out_dest_q;
  assign out_wen    = out_wen_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vector table, randomized traffic against a
// behavioural reference model, and hand-written reset sequences.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_op, out_funct;
  logic [31:0] out_rs_val, out_rt_val, out_imm;
  logic [4:0]  out_dest;
  logic        out_wen;

  logic [31:0] rf [32];

  int nCompared   = 0;
  int nMismatched = 0;

  operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_funct(out_funct),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm),
    .out_dest(out_dest), .out_wen(out_wen)
  );

  // Behavioural register file
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_ready;
    logic        exp_ready;
    logic        exp_valid;
    logic [4:0]  exp_dest;
    logic        exp_wen;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic [31:0] exp_imm;
  } vec_t;

  // Reference model state
  bit          mValid;
  logic [5:0]  mOp, mFunct;
  logic [31:0] mRs, mRt, mImm;
  logic [4:0]  mDest;
  bit          mWen;
  bit          mPend [32];
  bit          mReady;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] ins, input logic we,
                              input logic [4:0] wa, input logic [31:0] wd, input logic fl,
                              input logic ordy, input logic er, input logic ev,
                              input logic [4:0] ed, input logic ew, input logic [31:0] ers,
                              input logic [31:0] ert, input logic [31:0] eimm);
    vec_t v;
    v.in_valid = iv;  v.instr = ins;  v.wb_en = we;  v.wb_addr = wa;  v.wb_data = wd;
    v.flush = fl;  v.out_ready = ordy;  v.exp_ready = er;  v.exp_valid = ev;
    v.exp_dest = ed;  v.exp_wen = ew;  v.exp_rs = ers;  v.exp_rt = ert;  v.exp_imm = eimm;
    return v;
  endfunction

  // Opcode classes: which instructions write, where, and whether rt is read
  function automatic void decodeRef(input logic [31:0] ins, output bit hasDest,
                                    output logic [4:0] dest, output bit usesRt);
    hasDest = 0; dest = 5'd0; usesRt = 0;
    case (ins[31:26])
      6'h00:                    begin hasDest = 1; dest = ins[15:11]; usesRt = 1; end
      6'h08, 6'h0C, 6'h0D, 6'h23: begin hasDest = 1; dest = ins[20:16]; end
      6'h2B, 6'h04:             usesRt = 1;
      default:                  ;
    endcase
  endfunction

  function automatic logic [31:0] srcRef(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_addr == r) return wb_data;
    return rf[r];
  endfunction

  function automatic bit modelReady();
    bit hasDest, usesRt, haz;
    logic [4:0] dest;
    int regs[$];
    decodeRef(in_instr, hasDest, dest, usesRt);
    regs.push_back(int'(in_instr[25:21]));
    if (usesRt) regs.push_back(int'(in_instr[20:16]));
    if (hasDest && dest != 5'd0) regs.push_back(int'(dest));
    haz = 0;
    foreach (regs[i]) begin
      if (regs[i] != 0 && mPend[regs[i]] && !(wb_en && int'(wb_addr) == regs[i])) haz = 1;
    end
    return !flush && !haz && (!mValid || out_ready);
  endfunction

  function automatic void modelUpdate();
    bit hasDest, usesRt, acc;
    logic [4:0] dest;
    acc = in_valid && mReady;
    if (flush) begin
      if (mValid && mWen) mPend[mDest] = 0;
      mValid = 0;
    end
    if (wb_en) mPend[wb_addr] = 0;
    if (acc) begin
      decodeRef(in_instr, hasDest, dest, usesRt);
      mOp    = in_instr[31:26];
      mFunct = in_instr[5:0];
      mRs    = srcRef(in_instr[25:21]);
      mRt    = srcRef(in_instr[20:16]);
      mImm   = {{16{in_instr[15]}}, in_instr[15:0]};
      mDest  = hasDest ? dest : 5'd0;
      mWen   = hasDest && dest != 5'd0;
      if (mWen) mPend[dest] = 1;
      mValid = 1;
    end else if (!flush && mValid && out_ready) begin
      mValid = 0;
    end
  endfunction

  function automatic void modelReset();
    mValid = 0; mOp = '0; mFunct = '0; mRs = '0; mRt = '0; mImm = '0;
    mDest = '0; mWen = 0;
    foreach (mPend[i]) mPend[i] = 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_op", 32'(out_op), 32'd0);
    checkOutput("rst out_funct", 32'(out_funct), 32'd0);
    checkOutput("rst out_rs_val", out_rs_val, 32'd0);
    checkOutput("rst out_rt_val", out_rt_val, 32'd0);
    checkOutput("rst out_imm", out_imm, 32'd0);
    checkOutput("rst out_dest", 32'(out_dest), 32'd0);
    checkOutput("rst out_wen", 32'(out_wen), 32'd0);
  endtask

  // Asserts reset away from a clock edge, checks the cleared state, releases
  task automatic resetDut();
    in_valid = 0; in_instr = '0; wb_en = 0; wb_addr = '0; wb_data = '0;
    flush = 0; out_ready = 1;
    rst_n = 0;
    #2;
    checkResetState();
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive, check combinational outputs, clock, check registers
  task automatic applyStimulus(input vec_t v, input bit fromTable);
    in_valid = v.in_valid; in_instr = v.instr; wb_en = v.wb_en; wb_addr = v.wb_addr;
    wb_data = v.wb_data; flush = v.flush; out_ready = v.out_ready;
    @(negedge clk);
    mReady = modelReady();
    checkOutput("in_ready", 32'(in_ready), 32'(fromTable ? v.exp_ready : mReady));
    checkOutput("rf_raddr1", 32'(rf_raddr1), 32'(v.instr[25:21]));
    checkOutput("rf_raddr2", 32'(rf_raddr2), 32'(v.instr[20:16]));
    @(posedge clk);
    #1;
    modelUpdate();
    if (fromTable) begin
      checkOutput("out_valid", 32'(out_valid), 32'(v.exp_valid));
      if (v.exp_valid) begin
        checkOutput("out_dest", 32'(out_dest), 32'(v.exp_dest));
        checkOutput("out_wen", 32'(out_wen), 32'(v.exp_wen));
        checkOutput("out_rs_val", out_rs_val, v.exp_rs);
        checkOutput("out_rt_val", out_rt_val, v.exp_rt);
        checkOutput("out_imm", out_imm, v.exp_imm);
      end
    end else begin
      checkOutput("out_valid", 32'(out_valid), 32'(mValid));
      if (mValid) begin
        checkOutput("out_dest", 32'(out_dest), 32'(mDest));
        checkOutput("out_wen", 32'(out_wen), 32'(mWen));
        checkOutput("out_rs_val", out_rs_val, mRs);
        checkOutput("out_rt_val", out_rt_val, mRt);
        checkOutput("out_imm", out_imm, mImm);
      end
    end
    if (mValid) begin
      checkOutput("out_op", 32'(out_op), 32'(mOp));
      checkOutput("out_funct", 32'(out_funct), 32'(mFunct));
    end
  endtask

  vec_t tbl[$];
  logic [5:0] opPool [9] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h3F};

  initial begin
    vec_t v;
    logic [31:0] rnd;
    logic [15:0] low;

    rf[0] = 32'hFFFF_FFFF;
    for (int i = 1; i < 32; i++) rf[i] = 32'hA000_0000 | 32'(i);

    // Directed sequence: throughput, RAW bypass, $0, WAW, backpressure, flush
    tbl.push_back(mk(1, itype(6'h08, 0, 1, 16'h0005), 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 32'hA000_0001, 32'h5));
    tbl.push_back(mk(1, itype(6'h0D, 0, 2, 16'h0007), 0, 0, 0, 0, 1, 1, 1, 2, 1, 0, 32'hA000_0002, 32'h7));
    tbl.push_back(mk(1, itype(6'h08, 0, 3, 16'h0001), 0, 0, 0, 0, 1, 1, 1, 3, 1, 0, 32'hA000_0003, 32'h1));
    tbl.push_back(mk(1, rtype(3, 3, 4, 6'h20), 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, rtype(3, 3, 4, 6'h20), 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, rtype(3, 3, 4, 6'h20), 1, 3, 32'h1234, 0, 1, 1, 1, 4, 1, 32'h1234, 32'h1234, 32'h2020));
    tbl.push_back(mk(1, rtype(5, 0, 0, 6'h20), 0, 0, 0, 0, 1, 1, 1, 0, 0, 32'hA000_0005, 0, 32'h20));
    tbl.push_back(mk(1, itype(6'h08, 0, 6, 16'h0009), 0, 0, 0, 0, 1, 1, 1, 6, 1, 0, 32'hA000_0006, 32'h9));
    tbl.push_back(mk(1, itype(6'h08, 0, 6, 16'h000A), 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, itype(6'h08, 0, 6, 16'h000A), 1, 6, 32'h55, 0, 1, 1, 1, 6, 1, 0, 32'h55, 32'hA));
    tbl.push_back(mk(1, itype(6'h08, 0, 9, 16'h0033), 0, 0, 0, 0, 1, 1, 1, 9, 1, 0, 32'hA000_0009, 32'h33));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, itype(6'h0D, 0, 10, 16'h0044), 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 32'hA000_0009, 32'h33));
    tbl.push_back(mk(1, itype(6'h0D, 0, 10, 16'h0044), 0, 0, 0, 0, 1, 1, 1, 10, 1, 0, 32'hA000_000A, 32'h44));
    tbl.push_back(mk(1, itype(6'h23, 0, 7, 16'h0010), 0, 0, 0, 0, 1, 1, 1, 7, 1, 0, 32'hA000_0007, 32'h10));
    tbl.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, rtype(7, 7, 8, 6'h20), 0, 0, 0, 0, 1, 1, 1, 8, 1, 32'hA000_0007, 32'hA000_0007, 32'h4020));
    tbl.push_back(mk(1, itype(6'h08, 1, 11, 16'hFFFF), 1, 1, 32'hCAFE_0001, 0, 1, 1, 1, 11, 1, 32'hCAFE_0001, 32'hA000_000B, 32'hFFFF_FFFF));
    tbl.push_back(mk(1, itype(6'h2B, 12, 2, 16'h0004), 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, itype(6'h0F, 0, 2, 16'h0007), 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 32'hA000_0002, 32'h7));
    tbl.push_back(mk(0, 32'h0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, itype(6'h2B, 12, 2, 16'h0004), 1, 2, 32'h77, 0, 1, 1, 1, 0, 0, 32'hA000_000C, 32'h77, 32'h4));

    $display("[TB] reset");
    resetDut();

    $display("[TB] directed vectors: %0d", tbl.size());
    foreach (tbl[i]) applyStimulus(tbl[i], 1'b1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      rnd = $urandom();
      low = rnd[15:0];
      low[15] = rnd[31];
      low[14] = 1'b0;
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.in_valid  = ($urandom_range(0, 9) < 8);
      v.instr     = {opPool[$urandom_range(0, 8)], 5'($urandom_range(0, 15)),
                     5'($urandom_range(0, 15)), low};
      v.wb_en     = ($urandom_range(0, 99) < 35);
      v.wb_addr   = 5'($urandom_range(0, 15));
      v.wb_data   = $urandom();
      v.flush     = ($urandom_range(0, 99) < 5);
      v.out_ready = ($urandom_range(0, 9) < 7);
      applyStimulus(v, 1'b0);
    end

    $display("[TB] reset mid-stream, then reset mid-stall");
    resetDut();
    applyStimulus(mk(1, itype(6'h08, 0, 5, 16'h0001), 0, 0, 0, 0, 1, 1, 1, 5, 1, 0, 32'hA000_0005, 32'h1), 1'b1);
    applyStimulus(mk(1, rtype(5, 5, 6, 6'h20), 0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 32'hA000_0005, 32'h1), 1'b1);
    resetDut();
    applyStimulus(mk(1, rtype(5, 5, 6, 6'h20), 0, 0, 0, 0, 1, 1, 1, 6, 1, 32'hA000_0005, 32'hA000_0005, 32'h3020), 1'b1);
    applyStimulus(mk(0, 32'h0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
